alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute stage of the multi-cycle MIPS core.
//  - Selects ALU operand A: register rs, or the zero-extended shift amount.
//  - Performs the 4-bit-coded ALU operation, including a 64-bit multiply into hi/lo.
//  - Computes the branch-target PC from alu_zero.
//  - The FSM controller drives both en/done handshakes (ALU, branch) and sequences EXECUTE -> BRANCH.
// PARAMETERS
//  W     32  datapath width (fixed 32 for MIPS; shamt width = 5)
// PORTS
//  clk           in   1   single clock, rising edge
//  reset         in   1   synchronous, active-high
//  en            in   1   ALU request (level, held by controller until alu_done seen)
//  alu_control   in   4   operation code (see BEHAVIOUR)
//  read_data1    in   32  rs value
//  shamt         in   5   instr[10:6]
//  select_shamt  in   1   1: srcA = {27'b0,shamt}; 0: srcA = read_data1
//  alu_srcB      in   32  rt value or extended immediate (muxed upstream)
//  alu_result    out  32  registered result
//  hi, lo        out  32  registered multiply product halves
//  overflow      out  1   registered signed overflow flag
//  alu_zero      out  1   registered (alu_result == 0)
//  alu_done      out  1   ALU handshake done
//  branch_en     in   1   branch request (level)
//  branch        in   1   decoder Branch flag
//  imm           in   32  sign-extended word offset
//  pc            in   32  already-incremented PC (word address)
//  pc_out        out  32  next PC
//  branch_done   out  1   branch handshake done
// BEHAVIOUR
//  - Reset (sync, highest priority): all outputs = 0; overrides en/branch_en.
//    Reset during an active request aborts it; no done pulse.
//  - srcA mux: combinational, alu_srcA = select_shamt ? {27'b0,shamt} : read_data1.
//  - ALU handshake:
//    - en=1 & alu_done=0: compute at the edge, register outputs, alu_done=1 (1-cycle latency).
//    - en=1 & alu_done=1: hold all outputs and done.
//    - en=0: alu_done<=0; results hold their last value.
//    - Inputs change only while en=0.
//  - ALU op codes (A = srcA, B = srcB; shifts use A[4:0] as amount and B as operand):
//    - 0000 AND; 0001 OR; 0010 ADD (signed, sets overflow); 0011 XOR; 0100 NOR
//    - 0101 SLL B<<A; 0110 SUB A-B (signed, sets overflow); 0111 SLT signed -> 1/0
//    - 1000 SRL; 1001 SRA (arithmetic); 1010 MULT signed {hi,lo}=A*B; 1011 MULTU unsigned
//    - 1100 ADDU; 1101 SUBU (no overflow); 1110 SLTU unsigned -> 1/0; 1111 LUI B<<16
//  - Arithmetic and flag rules:
//    - All adds/subs wrap modulo 2^32.
//    - overflow updated on every op: 1 only for ADD/SUB signed overflow, else 0.
//    - MULT/MULTU: alu_result = lo of product. hi/lo change only on MULT/MULTU, otherwise hold.
//    - alu_zero computed from the new alu_result in the same edge.
//  - Branch handshake: same protocol as the ALU, using branch_en/branch_done.
//    - On the compute edge: pc_out = (branch & alu_zero) ? pc + imm : pc (32-bit wrap).
//    - Sampled alu_zero is the registered value from the preceding EXECUTE.
//    - branch_en=0: branch_done<=0; pc_out holds.
//  - The two handshakes are independent. Both requests in the same cycle must each complete correctly.
//    The branch uses the alu_zero value registered before that edge.
// STRUCTURE
//  - Shared package alu_exec_pkg: localparams ALU_AND..ALU_LUI (4-bit codes above), W=32.
//  - Sub-module branch_target_unit: branch handshake and pc_out logic.
//  - srcA mux, ALU datapath and ALU handshake stay in the top.
// TESTING
//  - ADD: A=0x7FFFFFFF, B=1, en=1 -> next edge alu_result=0x80000000, overflow=1, alu_done=1.
//    Drop en -> alu_done=0 one edge later.
//  - SUB equal: A=B=5 -> alu_result=0, alu_zero=1. Then branch=1, imm=0xFFFFFFFD, pc=10, branch_en=1
//    -> pc_out=7, branch_done=1.
//  - SRL shamt: select_shamt=1, shamt=4, read_data1=0xFFFF, B=0xF0000000 -> 0x0F000000.
//    SRA same -> 0xFF000000.
//  - MULT: A=-3, B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//    A following AND op leaves hi/lo unchanged.
//  - Branch not taken: alu_zero=0 or branch=0, pc=20, imm=8 -> pc_out=20.
//  - Reset asserted with en=1 mid-request -> all outputs 0, no alu_done.
//    SLT A=-1, B=1 -> 1; SLTU -> 0.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute stage.
// ALU operation codes and datapath width.
package alu_exec_pkg;
  localparam int W = 32;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_NOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_MULT  = 4'b1010;
  localparam logic [3:0] ALU_MULTU = 4'b1011;
  localparam logic [3:0] ALU_ADDU  = 4'b1100;
  localparam logic [3:0] ALU_SUBU  = 4'b1101;
  localparam logic [3:0] ALU_SLTU  = 4'b1110;
  localparam logic [3:0] ALU_LUI   = 4'b1111;
endpackage

// File: rtl/branch_target_unit.sv
// Branch target computation for the execute stage.
// Level request / done handshake, result held while idle.
module branch_target_unit
  import alu_exec_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         branch_en,
  input  logic         branch,
  input  logic         alu_zero,
  input  logic [W-1:0] imm,
  input  logic [W-1:0] pc,
  output logic [W-1:0] pc_out,
  output logic         branch_done
);

  // Compute the next PC once per request, hold until request drops
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out      <= '0;
      branch_done <= 1'b0;
    end else if (branch_en && !branch_done) begin
      pc_out      <= (branch && alu_zero) ? pc + imm : pc;
      branch_done <= 1'b1;
    end else if (!branch_en) begin
      branch_done <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: srcA mux, ALU with hi/lo multiply,
// and the branch target unit.
module alu_exec_unit
  import alu_exec_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [3:0]   alu_control,
  input  logic [W-1:0] read_data1,
  input  logic [4:0]   shamt,
  input  logic         select_shamt,
  input  logic [W-1:0] alu_srcB,
  output logic [W-1:0] alu_result,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         overflow,
  output logic         alu_zero,
  output logic         alu_done,
  input  logic         branch_en,
  input  logic         branch,
  input  logic [W-1:0] imm,
  input  logic [W-1:0] pc,
  output logic [W-1:0] pc_out,
  output logic         branch_done
);

  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   sum;
  logic [W-1:0]   diff;
  logic [2*W-1:0] prod_s;
  logic [2*W-1:0] prod_u;
  logic [W-1:0]   res;
  logic           ovf;
  logic           is_mul;
  logic [2*W-1:0] prod;

  assign a    = select_shamt ? {27'b0, shamt} : read_data1;
  assign b    = alu_srcB;
  assign sum  = a + b;
  assign diff = a - b;
  assign prod_s = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
  assign prod_u = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  // Decode the operation into the next result, flag and product
  always_comb begin
    res    = '0;
    ovf    = 1'b0;
    is_mul = 1'b0;
    prod   = '0;
    unique case (alu_control)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_ADD: begin
        res = sum;
        ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      ALU_XOR:  res = a ^ b;
      ALU_NOR:  res = ~(a | b);
      ALU_SLL:  res = b << a[4:0];
      ALU_SUB: begin
        res = diff;
        ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      ALU_SLT:  res = {31'b0, $signed(a) < $signed(b)};
      ALU_SRL:  res = b >> a[4:0];
      ALU_SRA:  res = $signed(b) >>> a[4:0];
      ALU_MULT: begin
        is_mul = 1'b1;
        prod   = prod_s;
        res    = prod_s[W-1:0];
      end
      ALU_MULTU: begin
        is_mul = 1'b1;
        prod   = prod_u;
        res    = prod_u[W-1:0];
      end
      ALU_ADDU: res = sum;
      ALU_SUBU: res = diff;
      ALU_SLTU: res = {31'b0, a < b};
      ALU_LUI:  res = b << 16;
      default:  res = '0;
    endcase
  end

  // Register ALU outputs once per request; hi/lo only on multiplies
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result <= '0;
      hi         <= '0;
      lo         <= '0;
      overflow   <= 1'b0;
      alu_zero   <= 1'b0;
      alu_done   <= 1'b0;
    end else if (en && !alu_done) begin
      alu_result <= res;
      overflow   <= ovf;
      alu_zero   <= (res == '0);
      alu_done   <= 1'b1;
      if (is_mul) begin
        hi <= prod[2*W-1:W];
        lo <= prod[W-1:0];
      end
    end else if (!en) begin
      alu_done <= 1'b0;
    end
  end

  branch_target_unit u_bt (
    .clk         (clk),
    .reset       (reset),
    .branch_en   (branch_en),
    .branch      (branch),
    .alu_zero    (alu_zero),
    .imm         (imm),
    .pc          (pc),
    .pc_out      (pc_out),
    .branch_done (branch_done)
  );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit.
// Hand-computed vectors for ALU, multiply and branch paths.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  alu_control;
  logic [31:0] read_data1;
  logic [4:0]  shamt;
  logic        select_shamt;
  logic [31:0] alu_srcB;
  logic [31:0] alu_result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        overflow;
  logic        alu_zero;
  logic        alu_done;
  logic        branch_en;
  logic        branch;
  logic [31:0] imm;
  logic [31:0] pc;
  logic [31:0] pc_out;
  logic        branch_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .alu_control  (alu_control),
    .read_data1   (read_data1),
    .shamt        (shamt),
    .select_shamt (select_shamt),
    .alu_srcB     (alu_srcB),
    .alu_result   (alu_result),
    .hi           (hi),
    .lo           (lo),
    .overflow     (overflow),
    .alu_zero     (alu_zero),
    .alu_done     (alu_done),
    .branch_en    (branch_en),
    .branch       (branch),
    .imm          (imm),
    .pc           (pc),
    .pc_out       (pc_out),
    .branch_done  (branch_done)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_go(input logic [3:0] op, input logic sel,
                        input logic [4:0] sh, input logic [31:0] ra,
                        input logic [31:0] rb);
    alu_control  = op;
    select_shamt = sel;
    shamt        = sh;
    read_data1   = ra;
    alu_srcB     = rb;
    en           = 1'b1;
    tick();
  endtask

  task automatic alu_idle();
    en = 1'b0;
    tick();
    check("done_low", alu_done, 0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; alu_control = 4'h0; read_data1 = '0;
    shamt = '0; select_shamt = 1'b0; alu_srcB = '0;
    branch_en = 1'b0; branch = 1'b0; imm = '0; pc = '0;
    tick(); tick();
    check("rst_res", alu_result, 0);
    check("rst_hilo", {hi, lo}, 0);
    check("rst_flags", {overflow, alu_zero, alu_done, branch_done}, 0);
    check("rst_pc", pc_out, 0);
    reset = 1'b0;
    tick();

    // ADD signed overflow
    alu_go(4'b0010, 0, 0, 32'h7FFF_FFFF, 32'h1);
    check("add_res", alu_result, 32'h8000_0000);
    check("add_ovf", overflow, 1);
    check("add_done", alu_done, 1);
    check("add_zero", alu_zero, 0);
    tick();
    check("hold_done", alu_done, 1);
    check("hold_res", alu_result, 32'h8000_0000);
    alu_idle();
    check("idle_res", alu_result, 32'h8000_0000);

    // SUB equal -> zero, then taken branch
    alu_go(4'b0110, 0, 0, 32'd5, 32'd5);
    check("sub_res", alu_result, 0);
    check("sub_zero", alu_zero, 1);
    check("sub_ovf", overflow, 0);
    alu_idle();
    branch = 1'b1; imm = 32'hFFFF_FFFD; pc = 32'd10; branch_en = 1'b1;
    tick();
    check("br_taken", pc_out, 32'd7);
    check("br_done", branch_done, 1);
    branch_en = 1'b0;
    tick();
    check("br_done_low", branch_done, 0);
    check("br_hold", pc_out, 32'd7);

    // Shifts by shamt
    alu_go(4'b1000, 1, 5'd4, 32'h0000_FFFF, 32'hF000_0000);
    check("srl", alu_result, 32'h0F00_0000);
    alu_idle();
    alu_go(4'b1001, 1, 5'd4, 32'h0000_FFFF, 32'hF000_0000);
    check("sra", alu_result, 32'hFF00_0000);
    alu_idle();
    alu_go(4'b0101, 0, 0, 32'd8, 32'h0000_00AB);
    check("sll", alu_result, 32'h0000_AB00);
    alu_idle();

    // Multiplies and hi/lo hold
    alu_go(4'b1010, 0, 0, 32'hFFFF_FFFD, 32'd7);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mult_res", alu_result, 32'hFFFF_FFEB);
    alu_idle();
    alu_go(4'b0000, 0, 0, 32'h0000_F0F0, 32'h0000_FF00);
    check("and_res", alu_result, 32'h0000_F000);
    check("and_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    alu_idle();

    // Branch not taken: alu_zero=0
    branch = 1'b1; pc = 32'd20; imm = 32'd8; branch_en = 1'b1;
    tick();
    check("nt_zero0", pc_out, 32'd20);
    branch_en = 1'b0;
    tick();

    alu_go(4'b1011, 0, 0, 32'hFFFF_FFFD, 32'd7);
    check("multu_hilo", {hi, lo}, 64'h0000_0006_FFFF_FFEB);
    alu_idle();

    // Branch not taken: branch=0 with alu_zero=1
    alu_go(4'b1101, 0, 0, 32'd9, 32'd9);
    check("subu_zero", alu_zero, 1);
    alu_idle();
    branch = 1'b0; pc = 32'd20; imm = 32'd8; branch_en = 1'b1;
    tick();
    check("nt_br0", pc_out, 32'd20);
    branch_en = 1'b0;
    tick();

    // Compares, LUI, SUB overflow, logic
    alu_go(4'b0111, 0, 0, 32'hFFFF_FFFF, 32'd1);
    check("slt", alu_result, 1);
    alu_idle();
    alu_go(4'b1110, 0, 0, 32'hFFFF_FFFF, 32'd1);
    check("sltu", alu_result, 0);
    check("sltu_zero", alu_zero, 1);
    alu_idle();
    alu_go(4'b1111, 0, 0, 32'h0, 32'h0000_1234);
    check("lui", alu_result, 32'h1234_0000);
    alu_idle();
    alu_go(4'b0110, 0, 0, 32'h8000_0000, 32'd1);
    check("sub_ovf_res", alu_result, 32'h7FFF_FFFF);
    check("sub_ovf", overflow, 1);
    alu_idle();
    alu_go(4'b1100, 0, 0, 32'h7FFF_FFFF, 32'd1);
    check("addu_ovf", overflow, 0);
    alu_idle();
    alu_go(4'b0100, 0, 0, 32'h0F0F_0000, 32'h0000_00FF);
    check("nor", alu_result, 32'hF0F0_FF00);
    alu_idle();
    alu_go(4'b0011, 0, 0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    check("xor", alu_result, 32'hF0F0_F0F0);
    alu_idle();
    alu_go(4'b0001, 0, 0, 32'hA000_0000, 32'h0000_000A);
    check("or", alu_result, 32'hA000_000A);
    check("or_zero", alu_zero, 0);
    alu_idle();

    // Both requests together: branch sees old alu_zero=0
    alu_control = 4'b1101; select_shamt = 1'b0;
    read_data1 = 32'd5; alu_srcB = 32'd5;
    branch = 1'b1; pc = 32'd100; imm = 32'd4;
    en = 1'b1; branch_en = 1'b1;
    tick();
    check("both_pc", pc_out, 32'd100);
    check("both_zero", alu_zero, 1);
    check("both_done", {alu_done, branch_done}, 2'b11);
    en = 1'b0; branch_en = 1'b0;
    tick();
    check("both_low", {alu_done, branch_done}, 0);

    // Reset mid-request aborts it
    alu_control = 4'b0010; read_data1 = 32'd3; alu_srcB = 32'd4;
    en = 1'b1; reset = 1'b1;
    tick();
    check("rst2_res", alu_result, 0);
    check("rst2_hilo", {hi, lo}, 0);
    check("rst2_flags", {overflow, alu_zero, alu_done, branch_done}, 0);
    check("rst2_pc", pc_out, 0);
    en = 1'b0; reset = 1'b0;
    tick();
    check("rst2_nodone", alu_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
